// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared link-protocol types and constants for the UART encoder/decoder
package game_pkg;

    typedef enum logic [2:0] {
        MSG_NONE    = 3'd0,
        MSG_CONNECT = 3'd1,
        MSG_SHOT    = 3'd2,
        MSG_POS     = 3'd3,
        MSG_SCORE   = 3'd4
    } tx_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CHECKSUM
    } tx_state_t;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    // Frame lengths include header and checksum bytes.
    localparam logic [2:0] LEN_CONNECT = 3'd2;
    localparam logic [2:0] LEN_SCORE   = 3'd3;
    localparam logic [2:0] LEN_SHOT    = 3'd5;
    localparam logic [2:0] LEN_POS     = 3'd5;

    function automatic logic [7:0] header_byte(input tx_msg_t msg);
        return {SYNC_NIBBLE, 1'b0, msg};
    endfunction

endpackage

// File: rtl/uart_tx_frame_pack.sv
// rtl/uart_tx_frame_pack.sv - combinational frame builder: message type + payload -> bytes + length
module uart_tx_frame_pack
    import game_pkg::*;
(
    input  tx_msg_t          msg,
    input  logic [23:0]      payload,
    output logic [4:0][7:0]  frame_bytes,
    output logic [2:0]       frame_len
);

    logic [7:0] hdr;

    assign hdr = header_byte(msg);

    // Position payloads are {x[11:0], y[11:0]}; score uses payload[7:0].
    always_comb begin
        frame_bytes    = '0;
        frame_len      = LEN_CONNECT;
        frame_bytes[0] = hdr;
        case (msg)
            MSG_SHOT, MSG_POS: begin
                frame_bytes[1] = payload[23:16];
                frame_bytes[2] = payload[15:8];
                frame_bytes[3] = payload[7:0];
                frame_bytes[4] = hdr ^ payload[23:16] ^ payload[15:8] ^ payload[7:0];
                frame_len      = LEN_SHOT;
            end
            MSG_SCORE: begin
                frame_bytes[1] = payload[7:0];
                frame_bytes[2] = hdr ^ payload[7:0];
                frame_len      = LEN_SCORE;
            end
            default: begin
                frame_bytes[1] = hdr;
                frame_len      = LEN_CONNECT;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - prioritised scheduler framing game messages into the UART TX FIFO
module uart_tx_scheduler
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        link_enable,
    input  logic        connect_req,
    input  logic        shot_req,
    input  logic [11:0] shot_xpos,
    input  logic [11:0] shot_ypos,
    input  logic        pos_req,
    input  logic [11:0] keeper_xpos,
    input  logic [11:0] keeper_ypos,
    input  logic        score_req,
    input  logic [2:0]  score_player,
    input  logic [2:0]  score_enemy,
    input  logic        match_end,
    input  logic        match_result,
    input  logic        tx_full,
    output logic [7:0]  w_data,
    output logic        wr_uart,
    output logic        busy,
    output logic        frame_sent
);

    logic            pend_connect, pend_shot, pend_pos, pend_score;
    logic [23:0]     shot_payload, pos_payload;
    logic [7:0]      score_payload;
    tx_msg_t         sel_msg;
    logic [23:0]     sel_payload;
    logic            start;
    tx_msg_t         frame_msg;
    logic [23:0]     frame_payload;
    logic [4:0][7:0] frame_bytes;
    logic [2:0]      frame_len;
    tx_state_t       state, state_nxt;
    logic [2:0]      byte_idx, byte_idx_nxt;

    // Fixed priority: CONNECT > SHOT > SCORE > POS.
    always_comb begin
        sel_msg     = MSG_NONE;
        sel_payload = '0;
        if (pend_connect) begin
            sel_msg = MSG_CONNECT;
        end else if (pend_shot) begin
            sel_msg     = MSG_SHOT;
            sel_payload = shot_payload;
        end else if (pend_score) begin
            sel_msg     = MSG_SCORE;
            sel_payload = {16'h0000, score_payload};
        end else if (pend_pos) begin
            sel_msg     = MSG_POS;
            sel_payload = pos_payload;
        end
    end

    assign start = (state == ST_IDLE) && link_enable && (sel_msg != MSG_NONE);

    // A new request in the cycle its type is taken re-arms the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_connect  <= 1'b0;
            pend_shot     <= 1'b0;
            pend_pos      <= 1'b0;
            pend_score    <= 1'b0;
            shot_payload  <= '0;
            pos_payload   <= '0;
            score_payload <= '0;
        end else begin
            if (link_enable && shot_req)
                shot_payload <= {shot_xpos, shot_ypos};
            if (link_enable && pos_req)
                pos_payload <= {keeper_xpos, keeper_ypos};
            if (link_enable && score_req)
                score_payload <= {score_player, score_enemy, match_end, match_result};
            pend_connect <= link_enable && (connect_req || (pend_connect && !(start && sel_msg == MSG_CONNECT)));
            pend_shot    <= link_enable && (shot_req    || (pend_shot    && !(start && sel_msg == MSG_SHOT)));
            pend_score   <= link_enable && (score_req   || (pend_score   && !(start && sel_msg == MSG_SCORE)));
            pend_pos     <= link_enable && (pos_req     || (pend_pos     && !(start && sel_msg == MSG_POS)));
        end
    end

    uart_tx_frame_pack u_pack (
        .msg         (frame_msg),
        .payload     (frame_payload),
        .frame_bytes (frame_bytes),
        .frame_len   (frame_len)
    );

    assign busy    = (state != ST_IDLE);
    assign wr_uart = busy && !tx_full;
    assign w_data  = busy ? frame_bytes[byte_idx] : 8'h00;

    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_HEADER;
                    byte_idx_nxt = 3'd0;
                end
            end
            ST_HEADER: begin
                if (wr_uart) begin
                    byte_idx_nxt = 3'd1;
                    state_nxt    = (frame_len == LEN_CONNECT) ? ST_CHECKSUM : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (wr_uart) begin
                    byte_idx_nxt = byte_idx + 3'd1;
                    if (byte_idx + 3'd1 == frame_len - 3'd1)
                        state_nxt = ST_CHECKSUM;
                end
            end
            ST_CHECKSUM: begin
                if (wr_uart) begin
                    byte_idx_nxt = 3'd0;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                byte_idx_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            byte_idx      <= 3'd0;
            frame_msg     <= MSG_NONE;
            frame_payload <= '0;
            frame_sent    <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_idx   <= byte_idx_nxt;
            frame_sent <= (state == ST_CHECKSUM) && wr_uart;
            if (start) begin
                frame_msg     <= sel_msg;
                frame_payload <= sel_payload;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_enable;
    logic        connect_req, shot_req, pos_req, score_req;
    logic [11:0] shot_xpos, shot_ypos, keeper_xpos, keeper_ypos;
    logic [2:0]  score_player, score_enemy;
    logic        match_end, match_result;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr_uart, busy, frame_sent;

    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .link_enable  (link_enable),
        .connect_req  (connect_req),
        .shot_req     (shot_req),
        .shot_xpos    (shot_xpos),
        .shot_ypos    (shot_ypos),
        .pos_req      (pos_req),
        .keeper_xpos  (keeper_xpos),
        .keeper_ypos  (keeper_ypos),
        .score_req    (score_req),
        .score_player (score_player),
        .score_enemy  (score_enemy),
        .match_end    (match_end),
        .match_result (match_result),
        .tx_full      (tx_full),
        .w_data       (w_data),
        .wr_uart      (wr_uart),
        .busy         (busy),
        .frame_sent   (frame_sent)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Message-level reference: pending set, latest payloads, and the frame being sent.
    bit          m_pend [1:4];
    logic [23:0] m_pl   [1:4];
    bit          m_busy, m_sent;
    logic [7:0]  m_b    [0:4];
    int          m_len, m_idx;
    int          prio   [4] = '{1, 2, 4, 3};
    logic [7:0]  log_q  [$];
    logic [7:0]  exp_q  [$];

    task automatic model_reset();
        for (int t = 1; t <= 4; t++) begin
            m_pend[t] = 1'b0;
            m_pl[t]   = '0;
        end
        m_busy = 1'b0;
        m_sent = 1'b0;
        m_len  = 0;
        m_idx  = 0;
        for (int i = 0; i < 5; i++) m_b[i] = 8'h00;
    endtask

    function automatic bit req_of(input int t);
        case (t)
            1: return connect_req;
            2: return shot_req;
            3: return pos_req;
            default: return score_req;
        endcase
    endfunction

    function automatic logic [23:0] req_payload(input int t);
        case (t)
            2: return {shot_xpos, shot_ypos};
            3: return {keeper_xpos, keeper_ypos};
            4: return {16'h0000, score_player, score_enemy, match_end, match_result};
            default: return 24'h0;
        endcase
    endfunction

    task automatic load_frame(input int t, input logic [23:0] p);
        logic [11:0] x, y;
        x = p[23:12];
        y = p[11:0];
        for (int i = 0; i < 5; i++) m_b[i] = 8'h00;
        m_b[0] = 8'hA0 | 8'(t);
        case (t)
            2, 3: begin
                m_b[1] = x[11:4];
                m_b[2] = {x[3:0], y[11:8]};
                m_b[3] = y[7:0];
                m_len  = 5;
            end
            4: begin
                m_b[1] = p[7:0];
                m_len  = 3;
            end
            default: m_len = 2;
        endcase
        for (int i = 0; i < m_len - 1; i++) m_b[m_len-1] = m_b[m_len-1] ^ m_b[i];
    endtask

    task automatic model_step();
        bit sent_n;
        sent_n = 1'b0;
        if (m_busy) begin
            if (!tx_full) begin
                m_idx++;
                if (m_idx == m_len) begin
                    m_busy = 1'b0;
                    sent_n = 1'b1;
                end
            end
        end else if (link_enable) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pend[prio[i]]) begin
                    load_frame(prio[i], m_pl[prio[i]]);
                    m_pend[prio[i]] = 1'b0;
                    m_busy = 1'b1;
                    m_idx  = 0;
                    break;
                end
            end
        end
        for (int t = 1; t <= 4; t++) begin
            if (!link_enable) begin
                m_pend[t] = 1'b0;
            end else if (req_of(t)) begin
                m_pend[t] = 1'b1;
                m_pl[t]   = req_payload(t);
            end
        end
        m_sent = sent_n;
    endtask

    task automatic tick();
        logic       exp_wr;
        logic [7:0] exp_d;
        @(negedge clk);
        exp_wr = m_busy && !tx_full;
        exp_d  = m_busy ? m_b[m_idx] : 8'h00;
        check("wr_uart", 32'(wr_uart), 32'(exp_wr));
        check("w_data", 32'(w_data), 32'(exp_d));
        check("busy", 32'(busy), 32'(m_busy));
        check("frame_sent", 32'(frame_sent), 32'(m_sent));
        if (wr_uart) log_q.push_back(w_data);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        connect_req = 1'b0;
        shot_req    = 1'b0;
        pos_req     = 1'b0;
        score_req   = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic async_reset();
        rst = 1'b1;
        model_reset();
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        log_q.delete();
    endtask

    task automatic set_shot(input logic [11:0] x, input logic [11:0] y);
        shot_xpos = x;
        shot_ypos = y;
        shot_req  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        link_enable = 1'b1;
        connect_req = 1'b0; shot_req = 1'b0; pos_req = 1'b0; score_req = 1'b0;
        shot_xpos = '0; shot_ypos = '0; keeper_xpos = '0; keeper_ypos = '0;
        score_player = '0; score_enemy = '0; match_end = 1'b0; match_result = 1'b0;
        tx_full = 1'b0;
        model_reset();
        run(2);
        check("rst_wr_uart", 32'(wr_uart), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_sent", 32'(frame_sent), 32'd0);
        rst = 1'b0;
        run(2);
        log_q.delete();

        connect_req = 1'b1;
        run(8);
        exp_q = {8'hA1, 8'hA1};
        compare_log("connect");

        set_shot(12'h3C5, 12'h1F0);
        run(10);
        exp_q = {8'hA2, 8'h3C, 8'h51, 8'hF0, 8'h3F};
        compare_log("shot");

        set_shot(12'h3C5, 12'h1F0);
        connect_req = 1'b1;
        keeper_xpos = 12'h123; keeper_ypos = 12'h456; pos_req = 1'b1;
        score_player = 3'd5; score_enemy = 3'd2; match_end = 1'b1; match_result = 1'b0; score_req = 1'b1;
        run(30);
        exp_q = {8'hA1, 8'hA1, 8'hA2, 8'h3C, 8'h51, 8'hF0, 8'h3F,
                 8'hA4, 8'hAA, 8'h0E, 8'hA3, 8'h12, 8'h34, 8'h56, 8'hD3};
        compare_log("all_four");

        set_shot(12'h3C5, 12'h1F0);
        run(3);
        tx_full = 1'b1;
        run(10);
        tx_full = 1'b0;
        run(8);
        exp_q = {8'hA2, 8'h3C, 8'h51, 8'hF0, 8'h3F};
        compare_log("stall");

        set_shot(12'h3C5, 12'h1F0);
        run(2);
        keeper_xpos = 12'h123; keeper_ypos = 12'h010; pos_req = 1'b1;
        run(1);
        keeper_ypos = 12'h020; pos_req = 1'b1;
        run(14);
        exp_q = {8'hA2, 8'h3C, 8'h51, 8'hF0, 8'h3F, 8'hA3, 8'h12, 8'h30, 8'h20, 8'hA1};
        compare_log("pos_latest");

        connect_req = 1'b1;
        score_req   = 1'b1;
        run(2);
        link_enable = 1'b0;
        run(8);
        link_enable = 1'b1;
        run(6);
        exp_q = {8'hA1, 8'hA1};
        compare_log("link_drop");

        set_shot(12'h3C5, 12'h1F0);
        run(4);
        async_reset();
        run(1);
        check("midrst_wr_uart", 32'(wr_uart), 32'd0);
        check("midrst_w_data", 32'(w_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        run(10);
        exp_q = {8'hA2, 8'h3C};
        compare_log("midrst");

        for (int c = 0; c < 3000; c++) begin
            shot_xpos    = 12'($urandom);
            shot_ypos    = 12'($urandom);
            keeper_xpos  = 12'($urandom);
            keeper_ypos  = 12'($urandom);
            score_player = 3'($urandom);
            score_enemy  = 3'($urandom);
            match_end    = 1'($urandom);
            match_result = 1'($urandom);
            connect_req  = ($urandom_range(0, 15) == 0);
            shot_req     = ($urandom_range(0, 7) == 0);
            pos_req      = ($urandom_range(0, 7) == 0);
            score_req    = ($urandom_range(0, 7) == 0);
            tx_full      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) link_enable = ~link_enable;
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
                run(1);
                rst = 1'b0;
            end
            run(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
